// File: rtl/run_ctrl_pkg.sv
// Shared types and helpers for the nRisc run controller.
package run_ctrl_pkg;

  localparam logic [7:0] DEFAULT_HALT_OPCODE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_HALTED  = 3'd4,
    ST_TIMEOUT = 3'd5
  } run_state_e;

  // Registered status bits presented to the bench / debug port
  typedef struct packed {
    logic cpu_rst;
    logic busy;
    logic halted;
    logic timed_out;
    logic bkpt_hit;
  } run_status_t;

  function automatic int unsigned bkpt_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_busy(input run_state_e s);
    return (s == ST_CLEAR) || (s == ST_RUN) || (s == ST_PAUSED);
  endfunction

endpackage

// File: rtl/bkpt_match.sv
// Parallel PC breakpoint comparators with a lowest-index-wins priority encoder.
module bkpt_match
  import run_ctrl_pkg::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned NUM_BKPT = 2,
  localparam int unsigned IDX_W   = bkpt_idx_w(NUM_BKPT)
) (
  input  logic [PC_W-1:0]          pc,
  input  logic [NUM_BKPT-1:0]      bkpt_en,
  input  logic [NUM_BKPT*PC_W-1:0] bkpt_addr,
  output logic                     hit,
  output logic [IDX_W-1:0]         idx
);

  logic [NUM_BKPT-1:0] match;

  always_comb begin : compare
    match = '0;
    for (int i = 0; i < int'(NUM_BKPT); i++) begin
      match[i] = bkpt_en[i] && (pc == bkpt_addr[i*PC_W +: PC_W]);
    end
  end

  // Scan from the top so the lowest matching comparator is the one left standing
  always_comb begin : encode
    hit = 1'b0;
    idx = '0;
    for (int i = int'(NUM_BKPT) - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/run_controller.sv
// Execution controller for the nRisc core: reset release, per-cycle gating,
// cycle counting, and stop on halt opcode, breakpoint or timeout.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int unsigned        PC_W        = 8,
  parameter int unsigned        INSTR_W     = 8,
  parameter int unsigned        CNT_W       = 16,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = INSTR_W'(DEFAULT_HALT_OPCODE),
  parameter int unsigned        NUM_BKPT    = 2,
  parameter int unsigned        MAX_CYCLES  = 1000,
  localparam int unsigned       IDX_W       = bkpt_idx_w(NUM_BKPT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     step_mode,
  input  logic                     step,
  input  logic [PC_W-1:0]          pc,
  input  logic [INSTR_W-1:0]       instrucao,
  input  logic [NUM_BKPT-1:0]      bkpt_en,
  input  logic [NUM_BKPT*PC_W-1:0] bkpt_addr,
  output logic                     cpu_enable_c,
  output logic                     cpu_rst,
  output logic                     busy,
  output logic                     halted,
  output logic                     timed_out,
  output logic                     bkpt_hit,
  output logic [IDX_W-1:0]         bkpt_idx,
  output logic [CNT_W-1:0]         cycle_count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  run_state_e        state_q, state_d;
  run_status_t       status_q, status_d;
  logic [IDX_W-1:0]  bkpt_idx_q, bkpt_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              skip_q, skip_d;

  logic              match_hit;
  logic [IDX_W-1:0]  match_idx;
  logic              halt_c, bkpt_c, tmo_c, stop_c, exec_req_c;

  bkpt_match #(
    .PC_W     (PC_W),
    .NUM_BKPT (NUM_BKPT)
  ) u_bkpt_match (
    .pc        (pc),
    .bkpt_en   (bkpt_en),
    .bkpt_addr (bkpt_addr),
    .hit       (match_hit),
    .idx       (match_idx)
  );

  // Stop conditions for the instruction currently presented by the core
  always_comb begin : stop_decode
    halt_c     = (instrucao == HALT_OPCODE);
    bkpt_c     = match_hit && !skip_q;
    tmo_c      = (MAX_CYCLES != 0) && (cnt_q == MAX_CNT);
    stop_c     = halt_c || bkpt_c || tmo_c;
    exec_req_c = (state_q == ST_RUN) || ((state_q == ST_PAUSED) && step);
  end

  assign cpu_enable_c = exec_req_c && !stop_c && !abort;

  always_comb begin : next_state
    state_d    = state_q;
    status_d   = status_q;
    bkpt_idx_d = bkpt_idx_q;
    cnt_d      = cnt_q;
    skip_d     = skip_q;

    // The skip only has to cover the first instruction executed after a breakpoint pause
    if (cpu_enable_c) begin
      if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      skip_d = 1'b0;
    end

    if (abort) begin
      state_d            = ST_IDLE;
      status_d.halted    = 1'b0;
      status_d.timed_out = 1'b0;
      status_d.bkpt_hit  = 1'b0;
      bkpt_idx_d         = '0;
      skip_d             = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_CLEAR;
        end
        ST_CLEAR: begin
          state_d = step_mode ? ST_PAUSED : ST_RUN;
        end
        ST_RUN, ST_PAUSED: begin
          if (exec_req_c) begin
            status_d.bkpt_hit = 1'b0;
            if (halt_c) begin
              state_d         = ST_HALTED;
              status_d.halted = 1'b1;
            end else if (bkpt_c) begin
              state_d           = ST_PAUSED;
              status_d.bkpt_hit = 1'b1;
              bkpt_idx_d        = match_idx;
              skip_d            = 1'b1;
            end else if (tmo_c) begin
              state_d            = ST_TIMEOUT;
              status_d.timed_out = 1'b1;
            end
          end else if ((state_q == ST_PAUSED) && start && !step_mode) begin
            state_d           = ST_RUN;
            status_d.bkpt_hit = 1'b0;
          end
        end
        ST_HALTED, ST_TIMEOUT: begin
          if (start) state_d = ST_CLEAR;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Entering CLEAR starts a fresh run
    if (state_d == ST_CLEAR) begin
      cnt_d              = '0;
      status_d.halted    = 1'b0;
      status_d.timed_out = 1'b0;
      status_d.bkpt_hit  = 1'b0;
      bkpt_idx_d         = '0;
      skip_d             = 1'b0;
    end

    status_d.cpu_rst = (state_d == ST_CLEAR);
    status_d.busy    = is_busy(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      status_q   <= '0;
      bkpt_idx_q <= '0;
      cnt_q      <= '0;
      skip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      bkpt_idx_q <= bkpt_idx_d;
      cnt_q      <= cnt_d;
      skip_q     <= skip_d;
    end
  end

  assign cpu_rst     = status_q.cpu_rst;
  assign busy        = status_q.busy;
  assign halted      = status_q.halted;
  assign timed_out   = status_q.timed_out;
  assign bkpt_hit    = status_q.bkpt_hit;
  assign bkpt_idx    = bkpt_idx_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: a simple incrementing-PC core model fed from a program table.
module tb_run_controller;

  localparam int unsigned PC_W     = 8;
  localparam int unsigned INSTR_W  = 8;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned NUM_BKPT = 2;
  localparam int unsigned MAX_CYC  = 20;

  typedef struct {
    logic             halted;
    logic             timed_out;
    logic             bkpt_hit;
    logic             idx;
    logic             busy;
    logic [CNT_W-1:0] cnt;
    int               execs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic step_mode = 1'b0;
  logic step = 1'b0;
  logic [PC_W-1:0] pc;
  logic [INSTR_W-1:0] instrucao;
  logic [NUM_BKPT-1:0] bkpt_en = '0;
  logic [NUM_BKPT*PC_W-1:0] bkpt_addr = '0;
  logic cpu_enable_c, cpu_rst, busy, halted, timed_out, bkpt_hit;
  logic [0:0] bkpt_idx;
  logic [CNT_W-1:0] cycle_count;

  logic [INSTR_W-1:0] prog [256];
  logic [PC_W-1:0] core_pc = '0;
  int exec_cnt = 0;
  int tests = 0;
  int fails = 0;
  exp_t exp_q[$];

  run_controller #(
    .PC_W        (PC_W),
    .INSTR_W     (INSTR_W),
    .CNT_W       (CNT_W),
    .HALT_OPCODE (8'h00),
    .NUM_BKPT    (NUM_BKPT),
    .MAX_CYCLES  (MAX_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .step_mode    (step_mode),
    .step         (step),
    .pc           (pc),
    .instrucao    (instrucao),
    .bkpt_en      (bkpt_en),
    .bkpt_addr    (bkpt_addr),
    .cpu_enable_c (cpu_enable_c),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .halted       (halted),
    .timed_out    (timed_out),
    .bkpt_hit     (bkpt_hit),
    .bkpt_idx     (bkpt_idx),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  // Core model: synchronous reset, PC advances by one on each enabled cycle
  always @(posedge clk) begin
    if (cpu_rst) core_pc <= '0;
    else if (cpu_enable_c) core_pc <= core_pc + 8'd1;
    if (cpu_enable_c) exec_cnt <= exec_cnt + 1;
  end

  assign pc        = core_pc;
  assign instrucao = prog[core_pc];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input int halt_at);
    for (int i = 0; i < 256; i++) prog[i] = (i == halt_at) ? 8'h00 : 8'h11;
  endtask

  task automatic launch(input logic sm);
    step_mode = sm;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic wait_stop(input int max_cyc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (halted || timed_out || bkpt_hit) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  function automatic exp_t mk(input logic h, input logic t, input logic b, input logic idx,
                              input logic bsy, input int c, input int x);
    exp_t e;
    e.halted = h; e.timed_out = t; e.bkpt_hit = b; e.idx = idx; e.busy = bsy;
    e.cnt = CNT_W'(c); e.execs = x;
    return e;
  endfunction

  task automatic test_reset();
    tick();
    tests++;
    if ({cpu_enable_c, cpu_rst, busy, halted, timed_out, bkpt_hit, bkpt_idx, cycle_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got en=%b rst=%b busy=%b h=%b t=%b b=%b idx=%b cnt=%0d exp all 0",
               cpu_enable_c, cpu_rst, busy, halted, timed_out, bkpt_hit, bkpt_idx, cycle_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_halt();
    logic ok; exp_t e; int e0;
    load_prog(5); bkpt_en = '0;
    e0 = exec_cnt;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 5, 5));
    launch(1'b0);
    tests++;
    if ({cpu_rst, busy, cycle_count} !== {1'b1, 1'b1, 16'd0}) begin
      fails++;
      $display("FAIL halt_clear got rst=%b busy=%b cnt=%0d exp rst=1 busy=1 cnt=0", cpu_rst, busy, cycle_count);
    end
    wait_stop(50, ok);
    e = exp_q.pop_front();
    tests++;
    if ({ok, halted, timed_out, bkpt_hit, bkpt_idx, busy} !== {1'b1, e.halted, e.timed_out, e.bkpt_hit, e.idx, e.busy}) begin
      fails++;
      $display("FAIL halt_status got ok=%b h=%b t=%b b=%b idx=%b busy=%b exp h=%b busy=%b",
               ok, halted, timed_out, bkpt_hit, bkpt_idx, busy, e.halted, e.busy);
    end
    tests++;
    if (cycle_count !== e.cnt || (exec_cnt - e0) !== e.execs) begin
      fails++;
      $display("FAIL halt_count got cnt=%0d execs=%0d exp %0d/%0d", cycle_count, exec_cnt - e0, e.cnt, e.execs);
    end
  endtask

  task automatic test_rerun_and_abort();
    logic ok; exp_t e; int e0;
    e0 = exec_cnt;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 5, 5));
    launch(1'b0);
    wait_stop(50, ok);
    e = exp_q.pop_front();
    tests++;
    if ({ok, halted, busy, cycle_count} !== {1'b1, e.halted, e.busy, e.cnt} || (exec_cnt - e0) !== e.execs) begin
      fails++;
      $display("FAIL rerun got ok=%b h=%b busy=%b cnt=%0d execs=%0d exp h=1 cnt=%0d execs=%0d",
               ok, halted, busy, cycle_count, exec_cnt - e0, e.cnt, e.execs);
    end
    do_abort();
    tests++;
    if ({halted, busy, cycle_count} !== {1'b0, 1'b0, 16'd5}) begin
      fails++;
      $display("FAIL abort_clear got h=%b busy=%b cnt=%0d exp h=0 busy=0 cnt=5", halted, busy, cycle_count);
    end
  endtask

  task automatic test_bkpt_resume();
    logic ok; exp_t e; int e0;
    load_prog(6);
    bkpt_addr = {8'd0, 8'd3}; bkpt_en = 2'b01;
    e0 = exec_cnt;
    exp_q.push_back(mk(0, 0, 1, 0, 1, 3, 3));
    launch(1'b0);
    wait_stop(50, ok);
    e = exp_q.pop_front();
    tests++;
    if ({ok, halted, timed_out, bkpt_hit, bkpt_idx, busy, cycle_count} !==
        {1'b1, e.halted, e.timed_out, e.bkpt_hit, e.idx, e.busy, e.cnt} || (exec_cnt - e0) !== e.execs) begin
      fails++;
      $display("FAIL bkpt_pause got ok=%b h=%b b=%b idx=%b busy=%b cnt=%0d execs=%0d exp b=1 idx=0 busy=1 cnt=3 execs=3",
               ok, halted, bkpt_hit, bkpt_idx, busy, cycle_count, exec_cnt - e0);
    end
    e0 = exec_cnt;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 6, 3));
    launch(1'b0);
    tests++;
    if ({bkpt_hit, cpu_enable_c} !== 2'b01) begin
      fails++;
      $display("FAIL bkpt_resume got b=%b en=%b exp b=0 en=1", bkpt_hit, cpu_enable_c);
    end
    wait_stop(50, ok);
    e = exp_q.pop_front();
    tests++;
    if ({ok, halted, bkpt_hit, busy, cycle_count} !== {1'b1, e.halted, e.bkpt_hit, e.busy, e.cnt} ||
        (exec_cnt - e0) !== e.execs) begin
      fails++;
      $display("FAIL bkpt_to_halt got ok=%b h=%b b=%b busy=%b cnt=%0d execs=%0d exp h=1 cnt=6 execs=3",
               ok, halted, bkpt_hit, busy, cycle_count, exec_cnt - e0);
    end
    do_abort();
  endtask

  task automatic test_bkpt_priority();
    logic ok; exp_t e;
    load_prog(10);
    bkpt_addr = {8'd4, 8'd4};
    for (int k = 0; k < 2; k++) begin
      bkpt_en = (k == 0) ? 2'b11 : 2'b10;
      exp_q.push_back(mk(0, 0, 1, k[0], 1, 4, 0));
      launch(1'b0);
      wait_stop(50, ok);
      e = exp_q.pop_front();
      tests++;
      if ({ok, bkpt_hit, bkpt_idx, busy, cycle_count} !== {1'b1, e.bkpt_hit, e.idx, e.busy, e.cnt}) begin
        fails++;
        $display("FAIL bkpt_prio_%0d got ok=%b b=%b idx=%b cnt=%0d exp b=1 idx=%b cnt=4",
                 k, ok, bkpt_hit, bkpt_idx, cycle_count, e.idx);
      end
      do_abort();
    end
    bkpt_en = '0;
  endtask

  task automatic test_single_step();
    exp_t e; int e0;
    load_prog(10);
    e0 = exec_cnt;
    launch(1'b1);
    tick();
    tick();
    tests++;
    if ({busy, cpu_enable_c, cycle_count} !== {1'b1, 1'b0, 16'd0}) begin
      fails++;
      $display("FAIL step_paused got busy=%b en=%b cnt=%0d exp busy=1 en=0 cnt=0", busy, cpu_enable_c, cycle_count);
    end
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(mk(0, 0, 0, 0, 1, k, k));
      step = 1'b1;
      #1;
      tests++;
      if (cpu_enable_c !== 1'b1) begin
        fails++;
        $display("FAIL step_enable_%0d got %b exp 1", k, cpu_enable_c);
      end
      tick();
      step = 1'b0;
      tick();
      tick();
      e = exp_q.pop_front();
      tests++;
      if ({busy, halted, cycle_count} !== {e.busy, e.halted, e.cnt} || (exec_cnt - e0) !== e.execs) begin
        fails++;
        $display("FAIL step_%0d got busy=%b h=%b cnt=%0d execs=%0d exp busy=1 cnt=%0d execs=%0d",
                 k, busy, halted, cycle_count, exec_cnt - e0, e.cnt, e.execs);
      end
    end
    do_abort();
  endtask

  task automatic test_timeout();
    logic ok; exp_t e; int e0; int e1;
    load_prog(-1);
    e0 = exec_cnt;
    exp_q.push_back(mk(0, 1, 0, 0, 0, int'(MAX_CYC), int'(MAX_CYC)));
    launch(1'b0);
    wait_stop(80, ok);
    e = exp_q.pop_front();
    tests++;
    if ({ok, halted, timed_out, bkpt_hit, busy, cycle_count} !== {1'b1, e.halted, e.timed_out, e.bkpt_hit, e.busy, e.cnt} ||
        (exec_cnt - e0) !== e.execs) begin
      fails++;
      $display("FAIL timeout got ok=%b h=%b t=%b busy=%b cnt=%0d execs=%0d exp t=1 cnt=%0d execs=%0d",
               ok, halted, timed_out, busy, cycle_count, exec_cnt - e0, e.cnt, e.execs);
    end
    e1 = exec_cnt;
    repeat (4) tick();
    tests++;
    if (cpu_enable_c !== 1'b0 || exec_cnt !== e1 || timed_out !== 1'b1) begin
      fails++;
      $display("FAIL timeout_hold got en=%b extra=%0d t=%b exp en=0 extra=0 t=1", cpu_enable_c, exec_cnt - e1, timed_out);
    end
    do_abort();
  endtask

  task automatic test_async_reset_and_abort();
    logic [CNT_W-1:0] held;
    load_prog(100);
    launch(1'b0);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({cpu_enable_c, cpu_rst, busy, halted, timed_out, bkpt_hit, bkpt_idx, cycle_count} !== '0) begin
      fails++;
      $display("FAIL async_reset got en=%b busy=%b cnt=%0d exp en=0 busy=0 cnt=0", cpu_enable_c, busy, cycle_count);
    end
    tick();
    rst_n = 1'b1;
    tick();
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    tick();
    tests++;
    if ({busy, cpu_rst, cpu_enable_c} !== 3'b000) begin
      fails++;
      $display("FAIL abort_start_idle got busy=%b rst=%b en=%b exp 0/0/0", busy, cpu_rst, cpu_enable_c);
    end
    launch(1'b0);
    repeat (3) tick();
    abort = 1'b1; start = 1'b1;
    #1;
    held = cycle_count;
    tests++;
    if (cpu_enable_c !== 1'b0) begin
      fails++;
      $display("FAIL abort_gate got en=%b exp 0", cpu_enable_c);
    end
    tick();
    abort = 1'b0; start = 1'b0;
    tick();
    tests++;
    if ({busy, cpu_enable_c} !== 2'b00 || cycle_count !== held || held !== 16'd2) begin
      fails++;
      $display("FAIL abort_start_run got busy=%b en=%b cnt=%0d exp busy=0 en=0 cnt=2", busy, cpu_enable_c, cycle_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    load_prog(255);
    test_reset();
    test_halt();
    test_rerun_and_abort();
    test_bkpt_resume();
    test_bkpt_priority();
    test_single_step();
    test_timeout();
    test_async_reset_and_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
